// File: rtl/cordic_pkg.sv
// cordic_pkg: shared defaults, FSM state type and Q-format limits for the CORDIC
// multiplier/divider pair.
package cordic_pkg;

  localparam int CORDIC_WL     = 16;
  localparam int CORDIC_FL     = 14;
  localparam int CORDIC_N_ITER = 15;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CORDIC_WL-1:0] QMAX = 16'h7FFF;
  localparam logic [CORDIC_WL-1:0] QMIN = 16'h8000;

endpackage

// File: rtl/cordic_div_stage.sv
// cordic_div_stage: one combinational linear-vectoring iteration; the divider
// reuses this single instance on every RUN cycle.
module cordic_div_stage
  import cordic_pkg::*;
#(
  parameter int WL = CORDIC_WL,
  parameter int FL = CORDIC_FL,
  parameter int IW = 4
) (
  input  logic signed [WL+1:0] x,
  input  logic signed [WL+1:0] y,
  input  logic signed [WL-1:0] z,
  input  logic        [IW-1:0] i,
  output logic signed [WL+1:0] y_next,
  output logic signed [WL-1:0] z_next
);

  logic signed [WL+1:0] x_sh;
  logic signed [WL-1:0] step;

  always_comb begin
    x_sh = x >>> i;
    step = {{(WL-1){1'b0}}, 1'b1} << (FL - int'(i));
    // Steer y toward zero; z records the signed weight of each subtraction.
    if (y[WL+1] == x[WL+1]) begin
      y_next = y - x_sh;
      z_next = z + step;
    end else begin
      y_next = y + x_sh;
      z_next = z - step;
    end
  end

endmodule

// File: rtl/cordic_divide.sv
// cordic_divide: linear-vectoring CORDIC divider, out = in1 / in2 in signed Q2.14.
// Defining CORDIC_DIV_SAT_EN adds a load-time range check that saturates and sets err.
module cordic_divide
  import cordic_pkg::*;
#(
  parameter int WL     = CORDIC_WL,
  parameter int FL     = CORDIC_FL,
  parameter int N_ITER = CORDIC_N_ITER
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [WL-1:0] in1,
  input  logic [WL-1:0] in2,
  output logic [WL-1:0] out,
  output logic          done,
  output logic          busy,
  output logic          err
);

  localparam int IW = $clog2(N_ITER);

  // Handshake: start is accepted on any edge where the block is idle (busy=0,
  // including the cycle done is high); done pulses once, N_ITER clocks later,
  // with out/err valid and held until the next done.
  state_t               state;
  logic signed [WL+1:0] x, y, y_next;
  logic signed [WL-1:0] z, z_next;
  logic [IW-1:0]        iter;
  logic                 exc;
  logic [WL-1:0]        exc_val;
  logic                 load_exc;
  logic [WL-1:0]        load_val;

`ifdef CORDIC_DIV_SAT_EN
  logic [WL+1:0] mag1, mag2x2;

  always_comb begin
    mag1   = in1[WL-1] ? -{{2{in1[WL-1]}}, in1} : {{2{in1[WL-1]}}, in1};
    mag2x2 = (in2[WL-1] ? -{{2{in2[WL-1]}}, in2} : {{2{in2[WL-1]}}, in2}) << 1;
  end
`endif

  always_comb begin
    load_exc = 1'b0;
    load_val = '0;
    if (in2 == '0) begin
      load_exc = 1'b1;
      if (in1[WL-1])
        load_val = QMIN;
      else if (in1 != '0)
        load_val = QMAX;
    end
`ifdef CORDIC_DIV_SAT_EN
    else if (mag1 >= mag2x2) begin
      load_exc = 1'b1;
      load_val = (in1[WL-1] == in2[WL-1]) ? QMAX : QMIN;
    end
`endif
  end

  cordic_div_stage #(
    .WL (WL),
    .FL (FL),
    .IW (IW)
  ) u_stage (
    .x      (x),
    .y      (y),
    .z      (z),
    .i      (iter),
    .y_next (y_next),
    .z_next (z_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      iter    <= '0;
      exc     <= 1'b0;
      exc_val <= '0;
      out     <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x       <= {{2{in2[WL-1]}}, in2};
            y       <= {{2{in1[WL-1]}}, in1};
            z       <= '0;
            iter    <= '0;
            exc     <= load_exc;
            exc_val <= load_val;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          y    <= y_next;
          z    <= z_next;
          iter <= iter + 1'b1;
          if (iter == IW'(N_ITER - 1)) begin
            out   <= exc ? exc_val : z_next;
            err   <= exc;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_divide.sv
// tb_cordic_divide: directed table, handshake/reset sequences and random operands
// checked against a real-arithmetic quotient model.
module tb_cordic_divide;
  import cordic_pkg::*;

  localparam int WL  = 16;
  localparam int LAT = 15;

  typedef struct {
    logic [WL-1:0] a;
    logic [WL-1:0] b;
    logic [WL-1:0] eo;
    logic          ee;
    bit            exact;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [WL-1:0] in1 = '0;
  logic [WL-1:0] in2 = '0;
  logic [WL-1:0] out;
  logic          done, busy, err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cordic_divide dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .out   (out),
    .done  (done),
    .busy  (busy),
    .err   (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input logic [WL-1:0] act, input real q);
    real d;
    n_cmp++;
    d = real'($signed(act)) - q;
    if (d < 0.0) d = -d;
    if (d > 2.0) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %f (+-2 LSB)", name, act, q);
    end
  endtask

  // Reference: exact quotient in LSB units, exceptions from the operand rules.
  function automatic void ref_div(input logic [WL-1:0] a, input logic [WL-1:0] b,
                                  output bit exact, output logic [WL-1:0] eo,
                                  output logic ee, output real q);
    int sa, sb, ma, mb;
    sa = $signed(a);
    sb = $signed(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    exact = 1'b0; eo = '0; ee = 1'b0; q = 0.0;
    if (sb == 0) begin
      exact = 1'b1;
      ee = 1'b1;
      eo = (sa > 0) ? 16'h7FFF : (sa < 0) ? 16'h8000 : 16'h0000;
    end else begin
      q = real'(sa) * 16384.0 / real'(sb);
      if (q > 32767.0) q = 32767.0;
      if (q < -32767.0) q = -32767.0;
`ifdef CORDIC_DIV_SAT_EN
      if (ma >= 2 * mb) begin
        exact = 1'b1;
        ee = 1'b1;
        eo = ((sa < 0) == (sb < 0)) ? 16'h7FFF : 16'h8000;
      end
`endif
    end
    if (ma < 0 || mb < 0) exact = 1'b1;
  endfunction

  // Waits for done from just after a sampling edge; busy must stay high meanwhile.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    do begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 40);
  endtask

  task automatic apply(input string name, input logic [WL-1:0] a, input logic [WL-1:0] b,
                       input bit exact, input logic [WL-1:0] eo, input logic ee, input real q);
    int lat;
    bit busy_ok;
    @(negedge clk);
    in1 = a; in2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in1 = WL'($urandom);
    in2 = WL'($urandom);
    wait_done(lat, busy_ok);
    check({name, ".latency"}, lat, LAT);
    check({name, ".busy_run"}, busy_ok, 1'b1);
    check({name, ".busy_done"}, busy, 1'b0);
    check({name, ".err"}, err, ee);
    if (exact) check({name, ".out"}, out, eo);
    else check_near({name, ".out"}, out, q);
    @(posedge clk); #1;
    check({name, ".done_width"}, done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    logic [WL-1:0] divs[5];
    logic [WL-1:0] r1;
    bit exact, busy_ok, seen;
    logic [WL-1:0] eo;
    logic ee;
    real q;
    int lat;

    vecs[0]  = '{16'h1000, 16'h2000, 16'h2000, 1'b0, 1'b0};
    vecs[1]  = '{16'h3000, 16'h4000, 16'h3000, 1'b0, 1'b0};
    vecs[2]  = '{16'hE000, 16'h4000, 16'hE000, 1'b0, 1'b0};
    vecs[3]  = '{16'h2000, 16'hC000, 16'hE000, 1'b0, 1'b0};
    vecs[4]  = '{16'hE000, 16'hC000, 16'h2000, 1'b0, 1'b0};
    vecs[5]  = '{16'h2000, 16'h0000, 16'h7FFF, 1'b1, 1'b1};
    vecs[6]  = '{16'hE000, 16'h0000, 16'h8000, 1'b1, 1'b1};
    vecs[7]  = '{16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1};
`ifdef CORDIC_DIV_SAT_EN
    vecs[8]  = '{16'h7FFF, 16'h2000, 16'h7FFF, 1'b1, 1'b1};
    vecs[9]  = '{16'h7FFF, 16'hE000, 16'h8000, 1'b1, 1'b1};
`else
    vecs[8]  = '{16'h7FFF, 16'h2000, 16'h7FFF, 1'b0, 1'b1};
    vecs[9]  = '{16'h7FFF, 16'hE000, 16'h8001, 1'b0, 1'b1};
`endif
    vecs[10] = '{16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{16'h8000, 16'h8000, 16'h4000, 1'b0, 1'b0};

    // Clock and reset.
    repeat (3) @(posedge clk);
    #1;
    check("reset.out", out, 16'h0000);
    check("reset.done", done, 1'b0);
    check("reset.busy", busy, 1'b0);
    check("reset.err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    foreach (vecs[k])
      apply($sformatf("vec%0d", k), vecs[k].a, vecs[k].b, vecs[k].exact,
            vecs[k].eo, vecs[k].ee, real'($signed(vecs[k].eo)));

    // Start pulsed while busy is ignored.
    @(negedge clk);
    in1 = 16'h1000; in2 = 16'h2000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) begin start = 1'b1; in1 = 16'h3000; in2 = 16'h4000; end
      if (lat == 4) start = 1'b0;
    end while (!done && lat < 40);
    check("busy_start.latency", lat, LAT);
    check_near("busy_start.out", out, 8192.0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("busy_start.no_extra_done", seen, 1'b0);

    // Start in the done cycle: back-to-back results.
    @(negedge clk);
    in1 = 16'hE000; in2 = 16'h4000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, busy_ok);
    check("b2b.first_latency", lat, LAT);
    r1 = out;
    check_near("b2b.first_out", r1, -8192.0);
    start = 1'b1; in1 = 16'h3000; in2 = 16'h4000;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, busy_ok);
    check("b2b.gap", lat + 1, LAT + 1);
    check("b2b.busy", busy_ok, 1'b1);
    check_near("b2b.second_out", out, 12288.0);

    // Reset in the middle of a run (leave err/out nonzero first).
    apply("pre_reset", 16'h2000, 16'h0000, 1'b1, 16'h7FFF, 1'b1, 0.0);
    @(negedge clk);
    in1 = 16'h1000; in2 = 16'h2000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset.out", out, 16'h0000);
    check("mid_reset.done", done, 1'b0);
    check("mid_reset.busy", busy, 1'b0);
    check("mid_reset.err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("mid_reset.no_done", seen, 1'b0);
    apply("post_reset", 16'h3000, 16'h4000, 1'b0, 16'h3000, 1'b0, 12288.0);

    // Random dividends against divisors whose shifts stay exact.
    divs[0] = 16'h2000; divs[1] = 16'h4000; divs[2] = 16'h8000;
    divs[3] = 16'hC000; divs[4] = 16'hE000;
    for (int n = 0; n < 40; n++) begin
      logic [WL-1:0] a, b;
      a = WL'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 16'h0000 : divs[$urandom_range(0, 4)];
      ref_div(a, b, exact, eo, ee, q);
      apply($sformatf("rand%0d_%h_%h", n, a, b), a, b, exact, eo, ee, q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
